// File: rtl/mem_pkg.sv
// Shared types and constants for the data memory responder.
package mem_pkg;

  // Width of one storage word.
  localparam int WORD_W = 32;

  // Wait counter width (WAIT_CYCLES is limited to 0..15).
  localparam int CNT_W = 4;

  // Responder control states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESPOND = 2'd2
  } state_e;

  // A request errors when the byte address is not word aligned or its word
  // index falls outside the storage array.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/mem_word_array.sv
// Word-wide storage array: one synchronous write port, one combinational
// read port, no reset (contents survive a responder reset).
module mem_word_array
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH_WORDS];

  // Commit a write on the rising edge when enabled.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: accepts one load/store at a time from the datapath,
// models a fixed access latency, checks alignment/range and returns the
// response with valid/ready handshaking.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              write_q;
  logic [31:0]       addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic [WORD_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;
  logic              busy_q;

  logic              transfer_s;
  logic              acc_write_s;
  logic [31:0]       acc_addr_s;
  logic [WORD_W-1:0] acc_wdata_s;
  logic              acc_err_s;
  logic              enter_rsp_s;
  logic              mem_we_s;
  logic [WORD_W-1:0] mem_rdata_s;
  logic [WORD_W-1:0] rsp_data_s;

  // Select the access fields: live request inputs in IDLE (the zero-wait case
  // enters RESPOND on the transfer edge itself), latched copies otherwise.
  always_comb begin
    transfer_s  = req_valid && req_ready_q && (state_q == ST_IDLE);
    if (state_q == ST_IDLE) begin
      acc_write_s = req_write;
      acc_addr_s  = req_addr;
      acc_wdata_s = req_wdata;
    end else begin
      acc_write_s = write_q;
      acc_addr_s  = addr_q;
      acc_wdata_s = wdata_q;
    end
    acc_err_s = addr_err(acc_addr_s, DEPTH_WORDS);
    if (state_q == ST_IDLE) begin
      enter_rsp_s = transfer_s && (WAIT_CYCLES == 0);
    end else if (state_q == ST_WAIT) begin
      enter_rsp_s = (cnt_q <= 4'd1);
    end else begin
      enter_rsp_s = 1'b0;
    end
    mem_we_s = enter_rsp_s && acc_write_s && !acc_err_s;
    if (acc_write_s || acc_err_s) begin
      rsp_data_s = '0;
    end else begin
      rsp_data_s = mem_rdata_s;
    end
  end

  mem_word_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk_i   (CLK),
    .we_i    (mem_we_s),
    .waddr_i (acc_addr_s[IDX_W+1:2]),
    .wdata_i (acc_wdata_s),
    .raddr_i (acc_addr_s[IDX_W+1:2]),
    .rdata_o (mem_rdata_s)
  );

  // Control FSM with wait counter and registered handshake/response outputs.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      write_q     <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (transfer_s) begin
            write_q     <= req_write;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            cnt_q       <= WAIT_LD;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (enter_rsp_s) begin
              state_q     <= ST_RESPOND;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= rsp_data_s;
              rsp_err_q   <= acc_err_s;
            end else begin
              state_q <= ST_WAIT;
            end
          end else begin
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (enter_rsp_s) begin
            state_q     <= ST_RESPOND;
            cnt_q       <= 4'd0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rsp_data_s;
            rsp_err_q   <= acc_err_s;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESPOND: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cnt_q       <= 4'd0;
          rsp_valid_q <= 1'b0;
          rsp_rdata_q <= 32'd0;
          rsp_err_q   <= 1'b0;
          req_ready_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: instance 0 has WAIT_CYCLES=0, instance 1 has
// WAIT_CYCLES=2. A word-array reference model predicts data, error and latency.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_n_a     = 2'b00;
  logic [1:0]       req_valid_a = 2'b00;
  logic [1:0]       req_write_a = 2'b00;
  logic [1:0][31:0] req_addr_a  = '0;
  logic [1:0][31:0] req_wdata_a = '0;
  logic [1:0]       rsp_ready_a = 2'b00;
  logic [1:0]       req_ready_a;
  logic [1:0]       rsp_valid_a;
  logic [1:0][31:0] rsp_rdata_a;
  logic [1:0]       rsp_err_a;
  logic [1:0]       busy_a;

  int vec_count = 0;
  int miscompares = 0;
  logic [31:0] ref_mem [2][256];

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
    .CLK(clk), .RESET(rst_n_a[0]), .req_valid(req_valid_a[0]), .req_write(req_write_a[0]),
    .req_addr(req_addr_a[0]), .req_wdata(req_wdata_a[0]), .req_ready(req_ready_a[0]),
    .rsp_valid(rsp_valid_a[0]), .rsp_ready(rsp_ready_a[0]), .rsp_rdata(rsp_rdata_a[0]),
    .rsp_err(rsp_err_a[0]), .busy(busy_a[0])
  );

  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut1 (
    .CLK(clk), .RESET(rst_n_a[1]), .req_valid(req_valid_a[1]), .req_write(req_write_a[1]),
    .req_addr(req_addr_a[1]), .req_wdata(req_wdata_a[1]), .req_ready(req_ready_a[1]),
    .rsp_valid(rsp_valid_a[1]), .rsp_ready(rsp_ready_a[1]), .rsp_rdata(rsp_rdata_a[1]),
    .rsp_err(rsp_err_a[1]), .busy(busy_a[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_count++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check every output of instance d against the idle/reset pattern.
  task automatic check_quiet(input int d, input string tag, input logic exp_ready);
    check({tag, "_req_ready"}, 32'(req_ready_a[d]), 32'(exp_ready));
    check({tag, "_rsp_valid"}, 32'(rsp_valid_a[d]), 32'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata_a[d], 32'd0);
    check({tag, "_rsp_err"},   32'(rsp_err_a[d]), 32'd0);
    check({tag, "_busy"},      32'(busy_a[d]), 32'd0);
  endtask

  // One full access on instance d, entered and left on a falling edge.
  task automatic access(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold, input bit keep_valid);
    int k;
    int lat;
    int wc;
    bit exp_err;
    logic [31:0] exp_rd;
    wc = (d == 1) ? 2 : 0;
    exp_err = (addr % 4 != 0) || ((addr / 4) >= 256);
    exp_rd = 32'd0;
    if (!wr && !exp_err) exp_rd = ref_mem[d][addr / 4];
    k = 0;
    while (req_ready_a[d] !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("req_ready_before_transfer", 32'(req_ready_a[d]), 32'd1);
    req_valid_a[d] = 1'b1;
    req_write_a[d] = wr;
    req_addr_a[d]  = addr;
    req_wdata_a[d] = wdata;
    @(posedge clk);
    @(negedge clk);
    if (!keep_valid) req_valid_a[d] = 1'b0;
    lat = 1;
    while (rsp_valid_a[d] !== 1'b1 && lat < 40) begin
      check("wait_busy", 32'(busy_a[d]), 32'd1);
      check("wait_req_ready", 32'(req_ready_a[d]), 32'd0);
      check("wait_rdata_zero", rsp_rdata_a[d], 32'd0);
      check("wait_err_zero", 32'(rsp_err_a[d]), 32'd0);
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(wc + 1));
    if (wr && !exp_err) ref_mem[d][addr / 4] = wdata;
    check("rsp_valid", 32'(rsp_valid_a[d]), 32'd1);
    check("rsp_rdata", rsp_rdata_a[d], exp_rd);
    check("rsp_err", 32'(rsp_err_a[d]), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_rsp_valid", 32'(rsp_valid_a[d]), 32'd1);
      check("hold_rsp_rdata", rsp_rdata_a[d], exp_rd);
      check("hold_rsp_err", 32'(rsp_err_a[d]), 32'(exp_err));
      check("hold_req_ready", 32'(req_ready_a[d]), 32'd0);
      check("hold_busy", 32'(busy_a[d]), 32'd1);
    end
    rsp_ready_a[d] = 1'b1;
    @(negedge clk);
    rsp_ready_a[d] = 1'b0;
    check_quiet(d, "after_rsp", 1'b1);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] w;
    int d;
    int sel;

    // Reset state.
    repeat (3) @(negedge clk);
    check_quiet(0, "reset0", 1'b0);
    check_quiet(1, "reset1", 1'b0);
    rst_n_a = 2'b11;
    check("ready_before_edge", 32'(req_ready_a[1]), 32'd0);
    @(negedge clk);
    check_quiet(0, "out_of_reset0", 1'b1);
    check_quiet(1, "out_of_reset1", 1'b1);

    // Give words 0..15 and 255 known contents in both instances.
    for (int dd = 0; dd < 2; dd++) begin
      for (int i = 0; i < 17; i++) begin
        a = (i == 16) ? 32'h0000_03FC : 32'(i * 4);
        access(dd, 1'b1, a, $urandom, 0, 1'b0);
      end
    end

    // Latency and read-after-write with two wait cycles.
    access(1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1'b0);
    access(1, 1'b0, 32'h0000_0010, 32'd0, 0, 1'b0);
    check("raw_model_deadbeef", ref_mem[1][4], 32'hDEAD_BEEF);

    // Misaligned store leaves storage untouched.
    access(1, 1'b1, 32'h0000_0013, 32'h1234_5678, 0, 1'b0);
    access(1, 1'b0, 32'h0000_0010, 32'd0, 1, 1'b0);

    // Out-of-range load and last/first-invalid word boundary.
    access(1, 1'b0, 32'h0000_0400, 32'd0, 0, 1'b0);
    access(1, 1'b0, 32'h0000_03FC, 32'd0, 0, 1'b0);

    // Backpressure with req_valid held: one further transfer only.
    access(1, 1'b0, 32'h0000_0010, 32'd0, 5, 1'b1);
    access(1, 1'b0, 32'h0000_0014, 32'd0, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("single_transfer_busy", 32'(busy_a[1]), 32'd0);
      check("single_transfer_rsp_valid", 32'(rsp_valid_a[1]), 32'd0);
    end

    // Reset one cycle into WAIT of a store: aborted, nothing committed.
    check("pre_reset_ready", 32'(req_ready_a[1]), 32'd1);
    req_valid_a[1] = 1'b1;
    req_write_a[1] = 1'b1;
    req_addr_a[1]  = 32'h0000_0020;
    req_wdata_a[1] = 32'hAAAA_5555;
    @(posedge clk);
    @(negedge clk);
    req_valid_a[1] = 1'b0;
    check("in_wait_busy", 32'(busy_a[1]), 32'd1);
    rst_n_a[1] = 1'b0;
    #1;
    check_quiet(1, "mid_wait_reset", 1'b0);
    repeat (2) @(negedge clk);
    check_quiet(1, "held_reset", 1'b0);
    rst_n_a[1] = 1'b1;
    @(negedge clk);
    check_quiet(1, "after_mid_reset", 1'b1);
    access(1, 1'b0, 32'h0000_0020, 32'd0, 0, 1'b0);

    // Zero-wait store then load of word 0.
    access(0, 1'b1, 32'h0000_0000, 32'hC0FF_EE01, 0, 1'b0);
    access(0, 1'b0, 32'h0000_0000, 32'd0, 2, 1'b0);
    access(0, 1'b0, 32'h0000_0002, 32'd0, 0, 1'b0);

    // Randomized traffic on both instances.
    for (int n = 0; n < 60; n++) begin
      d = n % 2;
      sel = $urandom_range(0, 9);
      if (sel <= 6)      a = 32'($urandom_range(0, 15)) * 32'd4;
      else if (sel == 7) a = 32'($urandom_range(0, 15)) * 32'd4 + 32'($urandom_range(1, 3));
      else if (sel == 8) a = 32'h0000_0400 + ($urandom & 32'hFFFF_F000);
      else               a = 32'h0000_03FC;
      w = $urandom;
      access(d, 1'($urandom_range(0, 1)), a, w, $urandom_range(0, 3), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
